// File: rtl/clmul_pkg.sv
// Shared definitions for the carry-less multiply arbiter: op encoding, FSM
// states, timing constants and the result-select helper.
package clmul_pkg;

  typedef enum logic [1:0] {
    OP_CLMUL  = 2'd0,
    OP_CLMULH = 2'd1,
    OP_CLMULR = 2'd2,
    OP_RSVD   = 2'd3
  } clmul_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_BUSY,
    S_DONE
  } clmul_state_t;

  localparam int unsigned CLMUL_LATENCY      = 7;
  localparam int unsigned CLMUL_IT_PER_CYCLE = 8;
  localparam int unsigned CLMUL_ITERS        = 32 / CLMUL_IT_PER_CYCLE;

  function automatic logic [31:0] clmul_select(input clmul_op_t op, input logic [63:0] p);
    logic [31:0] r;
    case (op)
      OP_CLMUL:  r = p[31:0];
      OP_CLMULH: r = p[63:32];
      OP_CLMULR: r = p[62:31];
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clmul_arb_if.sv
// Request/response bundle for one client port of clmul_arb.
interface clmul_arb_if;
  logic        valid;
  logic        ready;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  modport master (output valid, op, a, b, resp_ready,
                  input  ready, resp_valid, resp_data);
  modport slave  (input  valid, op, a, b, resp_ready,
                  output ready, resp_valid, resp_data);
endinterface

// File: rtl/clmul_arb_clmul.sv
// Iterative 32x32 carry-less multiplier: CLMUL_IT_PER_CYCLE product bits per
// non-stalled cycle; eoc rises the cycle after the last iteration.
module clmul
  import clmul_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        stall,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        eoc,
  output logic [63:0] p
);

  logic [63:0] a_sh_q, a_sh_d;
  logic [31:0] b_sh_q, b_sh_d;
  logic [63:0] acc_q, acc_d, acc_nx;
  logic [2:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    acc_nx = acc_q;
    for (int unsigned i = 0; i < CLMUL_IT_PER_CYCLE; i++) begin
      if (b_sh_q[i]) acc_nx = acc_nx ^ (a_sh_q << i);
    end
    if (!stall) begin
      if (start) begin
        a_sh_d = {32'b0, a};
        b_sh_d = b;
        acc_d  = '0;
        cnt_d  = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
      end else if (busy_q) begin
        acc_d  = acc_nx;
        a_sh_d = a_sh_q << CLMUL_IT_PER_CYCLE;
        b_sh_d = b_sh_q >> CLMUL_IT_PER_CYCLE;
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'(CLMUL_ITERS - 1)) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign eoc = done_q;
  assign p   = acc_q;

endmodule

// File: rtl/clmul_arb.sv
// Two-port round-robin arbiter around one shared carry-less multiplier.
// Optional: CLMUL_ARB_ZERO_BYPASS_EN skips the multiplier for zero operands.
module clmul_arb
  import clmul_pkg::*;
#(
  parameter bit RR_INIT = 1'b0
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         stall,
  input  logic         flush,
  clmul_arb_if.slave   p0,
  clmul_arb_if.slave   p1
);

  clmul_state_t state_q, state_d;
  logic         prio_q, prio_d;
  logic         owner_q, owner_d;
  clmul_op_t    op_q, op_d;
  logic [31:0]  a_q, a_d, b_q, b_d;
  logic [63:0]  prod_q, prod_d;
`ifdef CLMUL_ARB_ZERO_BYPASS_EN
  logic         zero_q, zero_d;
`endif

  logic        grant_vld, grant;
  logic        v0, v1, own_resp_ready;
  logic        mul_start, mul_eoc;
  logic [63:0] mul_p;
  logic [31:0] result;

  assign own_resp_ready = owner_q ? p1.resp_ready : p0.resp_ready;

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    prod_d    = prod_q;
`ifdef CLMUL_ARB_ZERO_BYPASS_EN
    zero_d    = zero_q;
`endif
    grant_vld = 1'b0;
    grant     = 1'b0;
    mul_start = 1'b0;
    v0        = p0.valid && !flush;
    v1        = p1.valid;
    case (state_q)
      S_IDLE: begin
        if (!stall && (v0 || v1)) begin
          grant_vld = 1'b1;
          grant     = prio_q ? v1 : !v0;
          owner_d   = grant;
          prio_d    = !grant;
          op_d      = clmul_op_t'(grant ? p1.op : p0.op);
          a_d       = grant ? p1.a : p0.a;
          b_d       = grant ? p1.b : p0.b;
`ifdef CLMUL_ARB_ZERO_BYPASS_EN
          zero_d    = (a_d == '0) || (b_d == '0);
`endif
          state_d   = S_START;
        end
      end
      S_START: begin
        if (!stall) begin
`ifdef CLMUL_ARB_ZERO_BYPASS_EN
          if (zero_q) begin
            prod_d  = '0;
            state_d = S_DONE;
          end else begin
            mul_start = 1'b1;
            state_d   = S_BUSY;
          end
`else
          mul_start = 1'b1;
          state_d   = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (!stall && mul_eoc) begin
          prod_d  = mul_p;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (!stall && own_resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Flush overrides stall; a killed START must not launch the multiplier.
    if (flush && !owner_q && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      mul_start = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      prio_q  <= RR_INIT;
      owner_q <= 1'b0;
      op_q    <= OP_CLMUL;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
`ifdef CLMUL_ARB_ZERO_BYPASS_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
`ifdef CLMUL_ARB_ZERO_BYPASS_EN
      zero_q  <= zero_d;
`endif
    end
  end

  clmul u_clmul (
    .clk    (clk),
    .resetn (resetn),
    .stall  (stall),
    .start  (mul_start),
    .a      (a_q),
    .b      (b_q),
    .eoc    (mul_eoc),
    .p      (mul_p)
  );

  assign result        = clmul_select(op_q, prod_q);
  assign p0.ready      = resetn && grant_vld && !grant;
  assign p1.ready      = resetn && grant_vld && grant;
  assign p0.resp_valid = (state_q == S_DONE) && !owner_q;
  assign p1.resp_valid = (state_q == S_DONE) && owner_q;
  assign p0.resp_data  = p0.resp_valid ? result : '0;
  assign p1.resp_data  = p1.resp_valid ? result : '0;

endmodule

// File: tb/tb_clmul_arb.sv
// Self-checking bench for clmul_arb: directed cases plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_clmul_arb;
  import clmul_pkg::*;

  logic clk = 1'b0;
  logic resetn, stall, flush;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  int   start_pulses = 0;

  clmul_arb_if p0_if ();
  clmul_arb_if p1_if ();

  clmul_arb #(.RR_INIT(1'b0)) dut (
    .clk    (clk),
    .resetn (resetn),
    .stall  (stall),
    .flush  (flush),
    .p0     (p0_if),
    .p1     (p1_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] p = '0;
    for (int i = 0; i < 32; i++)
      if (b[i]) p = p ^ ({32'b0, a} << i);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return p[62:31];
      default: return 32'h0;
    endcase
  endfunction

  // Reference model: one job at a time; a job either counts down its
  // remaining non-stalled cycles or waits for its response to be taken.
  bit          m_busy = 0, m_resp = 0, m_owner = 0, m_prio = 0;
  int          m_rem = 0;
  logic [31:0] m_data = '0;

  always @(negedge clk) begin
    bit idle, gv, g, zero;
    logic [3:0]  exp_ctl;
    logic [31:0] exp_d0, exp_d1;
    if (dut.u_clmul.start) start_pulses++;
    idle = !m_busy && !m_resp;
    gv = 0;
    g  = 0;
    if (idle && resetn && !stall) begin
      if (p0_if.valid && !flush || p1_if.valid) begin
        gv = 1;
        if (m_prio) g = p1_if.valid ? 1'b1 : 1'b0;
        else        g = (p0_if.valid && !flush) ? 1'b0 : 1'b1;
      end
    end
    exp_ctl = {gv && !g, gv && g, m_resp && !m_owner, m_resp && m_owner};
    exp_d0  = (m_resp && !m_owner) ? m_data : 32'h0;
    exp_d1  = (m_resp && m_owner) ? m_data : 32'h0;
    if (chk_en) begin
      check("ctl{rdy0,rdy1,rv0,rv1}",
            {60'b0, p0_if.ready, p1_if.ready, p0_if.resp_valid, p1_if.resp_valid},
            {60'b0, exp_ctl});
      check("p0_resp_data", {32'b0, p0_if.resp_data}, {32'b0, exp_d0});
      check("p1_resp_data", {32'b0, p1_if.resp_data}, {32'b0, exp_d1});
    end
    if (!resetn) begin
      m_busy = 0; m_resp = 0; m_prio = 0;
    end else if (flush && !m_owner && !idle) begin
      m_busy = 0; m_resp = 0;
    end else if (gv) begin
      m_busy  = 1;
      m_owner = g;
      m_prio  = !g;
      m_data  = g ? ref_result(p1_if.op, p1_if.a, p1_if.b)
                  : ref_result(p0_if.op, p0_if.a, p0_if.b);
      zero    = g ? (p1_if.a == 0 || p1_if.b == 0) : (p0_if.a == 0 || p0_if.b == 0);
`ifdef CLMUL_ARB_ZERO_BYPASS_EN
      m_rem   = zero ? 1 : CLMUL_LATENCY - 1;
      if (zero) m_data = 32'h0;
`else
      m_rem   = CLMUL_LATENCY - 1;
`endif
    end else if (m_busy && !stall) begin
      m_rem--;
      if (m_rem == 0) begin m_busy = 0; m_resp = 1; end
    end else if (m_resp && !stall && (m_owner ? p1_if.resp_ready : p0_if.resp_ready)) begin
      m_resp = 0;
    end
  end

  task automatic set_req(input int port, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    if (port == 0) begin p0_if.valid = 1; p0_if.op = op; p0_if.a = a; p0_if.b = b; end
    else           begin p1_if.valid = 1; p1_if.op = op; p1_if.a = a; p1_if.b = b; end
  endtask

  task automatic wait_accept(input int port, output int t);
    bit ok = 0;
    t = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_if.ready : p1_if.ready) begin ok = 1; t = cyc; end
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (port == 0) p0_if.valid = 0; else p1_if.valid = 0;
  endtask

  task automatic wait_resp(input int port, output int t, output logic [31:0] d);
    bit ok = 0;
    t = 0; d = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if ((port == 0) ? p0_if.resp_valid : p1_if.resp_valid) begin
        ok = 1; t = cyc; d = (port == 0) ? p0_if.resp_data : p1_if.resp_data;
      end
    end
    if (!ok) check("resp_timeout", 0, 1);
  endtask

  task automatic run_op(input int port, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat, output logic [31:0] d);
    int t0, t1;
    set_req(port, op, a, b);
    wait_accept(port, t0);
    wait_resp(port, t1, d);
    lat = t1 - t0;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1 resetn = 1;
  endtask

  initial begin
    int lat, t0, t1, n, cnt;
    logic [31:0] d, d0;
    logic [3:0] gseq;
    resetn = 0; stall = 0; flush = 0;
    p0_if.valid = 0; p0_if.op = 0; p0_if.a = 0; p0_if.b = 0; p0_if.resp_ready = 1;
    p1_if.valid = 0; p1_if.op = 0; p1_if.a = 0; p1_if.b = 0; p1_if.resp_ready = 1;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    check("reset_outputs", {p0_if.ready, p1_if.ready, p0_if.resp_valid, p1_if.resp_valid,
                            p0_if.resp_data, p1_if.resp_data}, '0);
    @(posedge clk); #1;

    run_op(0, 2'd0, 32'd3, 32'd3, lat, d);
    check("p0_clmul_3x3_lat", lat, 7);
    check("p0_clmul_3x3_data", d, 32'h5);

    run_op(1, 2'd1, 32'h80000000, 32'h80000000, lat, d);
    check("p1_clmulh_msb", d, 32'h40000000);
    run_op(1, 2'd2, 32'h80000000, 32'h80000000, lat, d);
    check("p1_clmulr_msb", d, 32'h80000000);
    run_op(1, 2'd0, 32'h80000000, 32'h80000000, lat, d);
    check("p1_clmul_msb", d, 32'h0);
    run_op(0, 2'd3, 32'hdeadbeef, 32'h12345677, lat, d);
    check("p0_reserved", d, 32'h0);

    // Simultaneous requests right after reset, then held for alternation.
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 2'd0, 32'h11, 32'h3);
    set_req(1, 2'd1, 32'hffffffff, 32'hffffffff);
    resetn = 1;
    @(negedge clk);
    check("first_grant_after_reset", {p0_if.ready, p1_if.ready}, 2'b10);
    n = 0; gseq = '0;
    for (int i = 0; i < 200 && n < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (p0_if.ready) begin gseq[3-n] = 1'b0; n++; end
      else if (p1_if.ready) begin gseq[3-n] = 1'b1; n++; end
    end
    check("grant_count", n, 4);
    check("grant_sequence", gseq, 4'b0101);
    @(posedge clk); #1 p0_if.valid = 0; p1_if.valid = 0;
    repeat (12) @(posedge clk);
    #1;

    // Stall in BUSY and a held response.
    set_req(0, 2'd0, 32'h0000abcd, 32'h00000f0f);
    wait_accept(0, t0);
    repeat (2) @(posedge clk);
    #1 stall = 1;
    repeat (3) @(posedge clk);
    #1 stall = 0; p0_if.resp_ready = 0;
    wait_resp(0, t1, d0);
    check("stall_latency", t1 - t0, 10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("held_resp_valid", p0_if.resp_valid, 1'b1);
      check("held_resp_data", p0_if.resp_data, d0);
    end
    @(posedge clk); #1 p0_if.resp_ready = 1;
    @(posedge clk); #1;

    // Flush of a busy port-0 op; p1 must be granted the next cycle.
    set_req(0, 2'd0, 32'h77, 32'h99);
    wait_accept(0, t0);
    repeat (2) @(posedge clk);
    #1 flush = 1; set_req(1, 2'd0, 32'h5, 32'h7);
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    check("idle_after_flush_p1_ready", p1_if.ready, 1'b1);
    @(posedge clk); #1 p1_if.valid = 0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin @(negedge clk); if (p0_if.resp_valid) cnt++; end
    check("flushed_p0_no_resp", cnt, 0);
    @(posedge clk); #1;

    // Reset during BUSY drops the op.
    set_req(1, 2'd1, 32'h1234, 32'h5678);
    wait_accept(1, t0);
    repeat (2) @(posedge clk);
    #1 resetn = 0;
    @(posedge clk); #1 resetn = 1;
    @(negedge clk);
    check("outputs_after_busy_reset", {p0_if.ready, p1_if.ready, p0_if.resp_valid,
          p1_if.resp_valid, p0_if.resp_data, p1_if.resp_data}, '0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (p1_if.resp_valid) cnt++; end
    check("reset_drops_op", cnt, 0);
    @(posedge clk); #1;

`ifdef CLMUL_ARB_ZERO_BYPASS_EN
    start_pulses = 0;
    run_op(0, 2'd0, 32'h0, 32'h1234, lat, d);
    check("bypass_latency", lat, 2);
    check("bypass_data", d, 32'h0);
    check("bypass_no_start", start_pulses, 0);
`endif

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      resetn = ($urandom_range(0, 199) != 0);
      stall  = ($urandom_range(0, 6) == 0);
      flush  = ($urandom_range(0, 19) == 0);
      p0_if.valid = ($urandom_range(0, 9) < 6);
      p1_if.valid = ($urandom_range(0, 9) < 6);
      p0_if.op = 2'($urandom_range(0, 3));
      p1_if.op = 2'($urandom_range(0, 3));
      p0_if.a = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      p0_if.b = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      p1_if.a = ($urandom_range(0, 9) == 0) ? 32'h80000000 : $urandom;
      p1_if.b = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      p0_if.resp_ready = ($urandom_range(0, 9) < 7);
      p1_if.resp_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge clk); #1;
    resetn = 1; stall = 0; flush = 0;
    p0_if.valid = 0; p1_if.valid = 0; p0_if.resp_ready = 1; p1_if.resp_ready = 1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
